// File: rtl/mux_n_reg_if.sv
// mux_n_reg_if: handshake and data bundle for mux_n_reg.
//   master : drives in_flat, sel, mode, in_valid, out_ready (upstream/downstream side)
//   slave  : drives in_ready, out, out_valid, out_sel, sel_err (the mux block)
// in_flat packs N inputs of WIDTH bits; input k sits at [k*WIDTH +: WIDTH].
interface mux_n_reg_if #(
   parameter int WIDTH = 32,
   parameter int N     = 8
);
   localparam int SEL_W = (N > 2) ? $clog2(N) : 1;

   logic [N*WIDTH-1:0] in_flat;
   logic [SEL_W-1:0]   sel;
   logic               mode;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   out;
   logic               out_valid;
   logic               out_ready;
   logic [SEL_W-1:0]   out_sel;
   logic               sel_err;

   modport master (
      output in_flat, sel, mode, in_valid, out_ready,
      input  in_ready, out, out_valid, out_sel, sel_err
   );

   modport slave (
      input  in_flat, sel, mode, in_valid, out_ready,
      output in_ready, out, out_valid, out_sel, sel_err
   );
endinterface

// File: rtl/mux_n_reg.sv
// mux_n_reg: N-way WIDTH-bit mux with a single registered output stage and
// valid/ready flow control on both sides.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : mux_n_reg_if slave modport (inputs, select, mode, handshakes,
//              registered out / out_sel / sel_err)
// mode=0 selects input sel directly; mode=1 walks an internal scan index,
// advancing once per accepted selection. An out-of-range direct select loads
// zero data and raises sel_err.
module mux_n_reg #(
   parameter int WIDTH = 32,
   parameter int N     = 8
) (
   input logic         clk,
   input logic         reset_n,
   mux_n_reg_if.slave  bus
);
   localparam int SEL_W = (N > 2) ? $clog2(N) : 1;
   localparam logic [SEL_W:0]   N_CMP = (SEL_W + 1)'(N);
   localparam logic [SEL_W-1:0] LAST  = SEL_W'(N - 1);

   logic [SEL_W-1:0] scan_idx;
   logic [SEL_W-1:0] eff_idx;
   logic             in_range;
   logic [WIDTH-1:0] sel_data;
   logic             accept;

   logic [WIDTH-1:0] out_r;
   logic             out_valid_r;
   logic [SEL_W-1:0] out_sel_r;
   logic             sel_err_r;

   assign bus.in_ready  = !out_valid_r || bus.out_ready;
   assign bus.out       = out_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_sel   = out_sel_r;
   assign bus.sel_err   = sel_err_r;

   assign accept   = bus.in_valid && bus.in_ready;
   assign eff_idx  = bus.mode ? scan_idx : bus.sel;
   assign in_range = {1'b0, eff_idx} < N_CMP;

   // Decoded select: an index matching no input leaves the data at zero,
   // which is exactly what an out-of-range select must load.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < N; k++) begin
         if (eff_idx == SEL_W'(k)) sel_data = bus.in_flat[k*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scan_idx    <= '0;
         out_r       <= '0;
         out_valid_r <= 1'b0;
         out_sel_r   <= '0;
         sel_err_r   <= 1'b0;
      end else begin
         // Leaving scan mode restarts the walk at input 0.
         if (!bus.mode) begin
            scan_idx <= '0;
         end else if (accept) begin
            scan_idx <= (scan_idx == LAST) ? '0 : scan_idx + SEL_W'(1);
         end

         if (accept) begin
            out_r       <= in_range ? sel_data : '0;
            out_sel_r   <= eff_idx;
            sel_err_r   <= !in_range;
            out_valid_r <= 1'b1;
         end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mux_n_reg.sv
module tb_mux_n_reg;
   logic clk;
   logic reset_n;
   int   checks;
   int   failures;

   mux_n_reg_if #(.WIDTH(32), .N(8)) b8 ();
   mux_n_reg_if #(.WIDTH(32), .N(6)) b6 ();

   mux_n_reg #(.WIDTH(32), .N(8)) u8 (.clk(clk), .reset_n(reset_n), .bus(b8));
   mux_n_reg #(.WIDTH(32), .N(6)) u6 (.clk(clk), .reset_n(reset_n), .bus(b6));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        mode;
      logic [2:0]  sel;
      logic        iv;
      logic        ordy;
      logic        exp_rdy;
      logic        exp_v;
      logic [31:0] exp_out;
      logic [2:0]  exp_sel;
      logic        exp_err;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [31:0] d(int k);
      return 32'h1000_0000 + 32'(k);
   endfunction

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endfunction

   function automatic void add(logic m, logic [2:0] s, logic iv, logic ordy, logic rdy,
                               logic v, logic [31:0] o, logic [2:0] os, logic e);
      vec_t t;
      t.mode = m; t.sel = s; t.iv = iv; t.ordy = ordy; t.exp_rdy = rdy;
      t.exp_v = v; t.exp_out = o; t.exp_sel = os; t.exp_err = e;
      tbl.push_back(t);
   endfunction

   task automatic step8();
      @(posedge clk);
      #1;
   endtask

   task automatic check8(string nm, logic v, logic [31:0] o, logic [2:0] os, logic e);
      chk({nm, "_valid"}, 32'(b8.out_valid), 32'(v));
      chk({nm, "_out"},   b8.out,            o);
      chk({nm, "_sel"},   32'(b8.out_sel),   32'(os));
      chk({nm, "_err"},   32'(b8.sel_err),   32'(e));
   endtask

   task automatic check6(string nm, logic v, logic [31:0] o, logic [2:0] os, logic e);
      chk({nm, "_valid"}, 32'(b6.out_valid), 32'(v));
      chk({nm, "_out"},   b6.out,            o);
      chk({nm, "_sel"},   32'(b6.out_sel),   32'(os));
      chk({nm, "_err"},   32'(b6.sel_err),   32'(e));
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      // direct select, then drain
      add(0, 5, 1, 1, 1, 1, d(5), 5, 0);
      add(0, 0, 0, 1, 1, 0, d(5), 5, 0);
      // backpressure: accept 2, stall three cycles with 6 offered, then release
      add(0, 2, 1, 0, 1, 1, d(2), 2, 0);
      add(0, 6, 1, 0, 0, 1, d(2), 2, 0);
      add(0, 6, 1, 0, 0, 1, d(2), 2, 0);
      add(0, 6, 1, 0, 0, 1, d(2), 2, 0);
      add(0, 6, 1, 1, 1, 1, d(6), 6, 0);
      add(0, 6, 0, 1, 1, 0, d(6), 6, 0);
      // scan for 10 accepts: wraps 7 -> 0
      for (int i = 0; i < 10; i++) add(1, 0, 1, 1, 1, 1, d(i % 8), 3'(i % 8), 0);
      // one direct cycle restarts the scan at 0
      add(0, 0, 0, 1, 1, 0, d(1), 1, 0);
      add(1, 0, 1, 1, 1, 1, d(0), 0, 0);
      add(1, 0, 0, 1, 1, 0, d(0), 0, 0);
      // back-to-back drain + accept, no bubble
      begin
         logic [2:0] seq [8];
         seq = '{3'd7, 3'd3, 3'd1, 3'd4, 3'd0, 3'd6, 3'd2, 3'd5};
         for (int i = 0; i < 8; i++) add(0, seq[i], 1, 1, 1, 1, d(seq[i]), seq[i], 0);
      end
      // mode change while a result is held does not disturb it
      add(0, 3, 1, 1, 1, 1, d(3), 3, 0);
      add(1, 3, 1, 0, 0, 1, d(3), 3, 0);
      add(1, 3, 1, 1, 1, 1, d(0), 0, 0);

      b8.in_flat = '0;
      b6.in_flat = '0;
      for (int k = 0; k < 8; k++) b8.in_flat[k*32 +: 32] = d(k);
      for (int k = 0; k < 6; k++) b6.in_flat[k*32 +: 32] = d(k);
      b8.sel = '0; b8.mode = 1'b0; b8.in_valid = 1'b0; b8.out_ready = 1'b0;
      b6.sel = '0; b6.mode = 1'b0; b6.in_valid = 1'b0; b6.out_ready = 1'b0;

      reset_n = 1'b0;
      b8.in_valid = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      check8("rst_hold", 0, 32'h0, 0, 0);
      chk("rst_in_ready", 32'(b8.in_ready), 32'd1);
      b8.in_valid = 1'b0;
      #2 reset_n = 1'b1;
      step8();
      check8("post_rst", 0, 32'h0, 0, 0);

      foreach (tbl[i]) begin
         b8.mode      = tbl[i].mode;
         b8.sel       = tbl[i].sel;
         b8.in_valid  = tbl[i].iv;
         b8.out_ready = tbl[i].ordy;
         #1;
         chk($sformatf("v%0d_in_ready", i), 32'(b8.in_ready), 32'(tbl[i].exp_rdy));
         @(posedge clk);
         #1;
         check8($sformatf("v%0d", i), tbl[i].exp_v, tbl[i].exp_out, tbl[i].exp_sel, tbl[i].exp_err);
      end

      // reset mid-stream with a held scan result
      b8.mode = 1'b0; b8.in_valid = 1'b0; b8.out_ready = 1'b1;
      step8();
      b8.mode = 1'b1; b8.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) step8();
      check8("scan4_pre", 1, d(3), 3, 0);
      b8.in_valid = 1'b0; b8.out_ready = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check8("async_rst", 0, 32'h0, 0, 0);
      b8.in_valid = 1'b1; b8.out_ready = 1'b1;
      step8();
      check8("rst_no_accept", 0, 32'h0, 0, 0);
      #2 reset_n = 1'b1;
      step8();
      check8("rst_first_scan", 1, d(0), 0, 0);
      b8.in_valid = 1'b0;
      step8();

      // N=6: out-of-range direct select, recovery, and scan wrap at 5
      b6.out_ready = 1'b1;
      b6.sel = 3'd7; b6.in_valid = 1'b1;
      @(posedge clk); #1;
      check6("n6_sel7", 1, 32'h0, 7, 1);
      b6.sel = 3'd3;
      @(posedge clk); #1;
      check6("n6_sel3", 1, d(3), 3, 0);
      b6.sel = 3'd6;
      @(posedge clk); #1;
      check6("n6_sel6", 1, 32'h0, 6, 1);
      b6.mode = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         check6($sformatf("n6_scan%0d", i), 1, d(i % 6), 3'(i % 6), 0);
      end
      b6.in_valid = 1'b0;
      @(posedge clk); #1;
      check6("n6_drain", 0, d(0), 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
